asc_hex_parser: RTL and testbench
=================================

// Module: asc_hex_parser
// PURPOSE
//  Parses a stream of ASCII characters (e.g. from a UART receiver) into binary words.
//  Accumulates hex digits '0'-'9' and 'a'-'f' MSB-first. A delimiter emits the word on a valid/ready output.
//  Inverse of the nibble-to-ASCII path used for hex dumps; sits between the character receiver and command logic.
// PARAMETERS
//  DIGITS   8   max hex digits per word, legal 1..16; word width = 4*DIGITS
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  rst_n        in   1          synchronous reset, active-low
//  char_valid   in   1          char_data valid
//  char_data    in   8          ASCII character
//  char_ready   out  1          parser accepts char this cycle
//  word_valid   out  1          parsed word available
//  word_data    out  4*DIGITS   parsed value, zero-extended, last digit in [3:0]
//  word_ndig    out  5          number of digits in word_data (1..DIGITS)
//  word_ready   in   1          consumer takes word this cycle
//  err          out  1          one-cycle error pulse
//  err_code     out  2          01 illegal char, 10 digit overflow; held until next error
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state IDLE; acc, count, word_data, word_ndig, err_code = 0.
//    word_valid = 0, err = 0. char_ready = 0 while rst_n low.
//  - Char accepted iff char_valid & char_ready. One char per clock max.
//  - char_ready = 1 in IDLE/ACCUM/SKIP; 0 in OUT.
//  - Classes: DIGIT = 0x30-0x39, 0x61-0x66 (+0x41-0x46 per CONFIGURATION).
//    DELIM = 0x0D, 0x0A, 0x20, 0x2C. Everything else = ILLEGAL.
//  - Nibble: '0'-'9' -> c-0x30; 'a'-'f' -> c-0x57; 'A'-'F' -> c-0x37.
//  - IDLE:
//      DIGIT -> acc={0,nib}, count=1, ACCUM.
//      DELIM -> consumed, stay IDLE, no word.
//      ILLEGAL -> err, code 01, SKIP.
//  - ACCUM:
//      DIGIT with count<DIGITS -> acc={acc[4*DIGITS-5:0],nib}, count+1.
//      DIGIT with count==DIGITS -> err, code 10, acc cleared, SKIP.
//      DELIM -> word_data=acc, word_ndig=count, word_valid=1, OUT.
//      ILLEGAL -> err, code 01, acc cleared, SKIP.
//  - SKIP: discard DIGIT/ILLEGAL with no further err pulses; DELIM -> IDLE, no word.
//  - OUT: word_valid, word_data and word_ndig held stable until word_ready.
//    On word_valid & word_ready: next cycle word_valid=0, acc/count=0, IDLE.
//    word_data keeps its last value.
//  - Latency: delimiter accepted at edge N -> word_valid high after edge N.
//    Error char accepted at edge N -> err high for exactly one cycle after edge N.
//  - word_ready while word_valid=0 is ignored.
//    char_valid during OUT is not consumed; the source must hold it.
//  - Reset mid-word or mid-OUT discards acc and the pending word; no word or err is emitted.
// CONFIGURATION
//  ASC_HEX_UPPER_EN defined:   'A'-'F' (0x41-0x46) are DIGITs, same values as 'a'-'f'.
//  ASC_HEX_UPPER_EN undefined: 'A'-'F' are ILLEGAL (err code 01). Matches lower-case-only hex output.
// TESTING
//  1. '1','a','3',0x0D -> one word: word_data=0x1A3, word_ndig=3; err never high.
//  2. 'F','F',0x0A: with ASC_HEX_UPPER_EN -> word 0xFF, ndig 2.
//     Without it -> err pulse on the first 'F', code 01; no word.
//  3. DIGITS=8, "123456789 " -> err pulse on '9', code 10; no word.
//     Then "7 " -> word 0x7, ndig 1.
//  4. "ab " with word_ready low 5 cycles after word_valid ->
//     char_ready=0 and word_data=0xAB stable for all 5 cycles; one word on release.
//  5. "12", rst_n low 1 cycle, then "3 " -> single word 0x3, ndig 1.
//  6. 0x20,0x2C,0x0D back-to-back in IDLE -> all consumed, char_ready stays 1; no word, no err.

Source files
------------

// File: rtl/asc_hex_parser_if.sv
// asc_hex_parser_if: character-in / word-out handshake bundle for asc_hex_parser
//  char_valid/char_data/char_ready : ASCII character stream into the parser
//  word_valid/word_data/word_ndig/word_ready : parsed word stream out of the parser
//  err/err_code : one-cycle error pulse and sticky error code
interface asc_hex_parser_if #(parameter int DIGITS = 8);
  logic                  char_valid;
  logic [7:0]            char_data;
  logic                  char_ready;
  logic                  word_valid;
  logic [4*DIGITS-1:0]   word_data;
  logic [4:0]            word_ndig;
  logic                  word_ready;
  logic                  err;
  logic [1:0]            err_code;
  modport master(
    output char_valid, char_data, word_ready,
    input  char_ready, word_valid, word_data, word_ndig, err, err_code
  );
  modport slave(
    input  char_valid, char_data, word_ready,
    output char_ready, word_valid, word_data, word_ndig, err, err_code
  );
endinterface

// File: rtl/asc_hex_parser.sv
// asc_hex_parser: turns an ASCII hex character stream into binary words on a valid/ready port
//  clk, rst_n : rising-edge clock, synchronous active-low reset
//  bus        : asc_hex_parser_if slave (char in, word out, err/err_code)
//  DIGITS     : max hex digits per word (1..16), word width 4*DIGITS
//  ASC_HEX_UPPER_EN : when defined, 'A'-'F' are accepted as digits
module asc_hex_parser #(
  parameter int DIGITS = 8
) (
  input logic          clk,
  input logic          rst_n,
  asc_hex_parser_if.slave bus
);
  localparam int W = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, ACCUM, SKIP, OUT} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d, word_data_q, word_data_d;
  logic [4:0]     cnt_q, cnt_d, word_ndig_q, word_ndig_d;
  logic           word_valid_q, word_valid_d, err_q, err_d;
  logic [1:0]     err_code_q, err_code_d;
  logic [7:0]     c;
  logic [3:0]     nib;
  logic           is_dig, is_delim, take;
  assign c = bus.char_data;
`ifdef ASC_HEX_UPPER_EN
  assign is_dig = (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46);
`else
  assign is_dig = (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66);
`endif
  assign is_delim = c == 8'h0D || c == 8'h0A || c == 8'h20 || c == 8'h2C;
  // letters of either case have bit 6 set and low nibble 1..6, so +9 yields A..F
  assign nib = c[6] ? c[3:0] + 4'd9 : c[3:0];
  assign bus.char_ready = rst_n & (state_q != OUT);
  assign take = bus.char_valid & bus.char_ready;
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    word_data_d  = word_data_q;
    word_ndig_d  = word_ndig_q;
    word_valid_d = word_valid_q;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    case (state_q)
      IDLE: if (take) begin
        if (is_dig) begin
          acc_d   = W'(nib);
          cnt_d   = 5'd1;
          state_d = ACCUM;
        end else if (!is_delim) begin
          err_d      = 1'b1;
          err_code_d = 2'b01;
          state_d    = SKIP;
        end
      end
      ACCUM: if (take) begin
        if (is_delim) begin
          word_data_d  = acc_q;
          word_ndig_d  = cnt_q;
          word_valid_d = 1'b1;
          state_d      = OUT;
        end else if (is_dig && cnt_q < 5'(DIGITS)) begin
          acc_d = W'({acc_q, nib});
          cnt_d = cnt_q + 5'd1;
        end else begin
          err_d      = 1'b1;
          err_code_d = is_dig ? 2'b10 : 2'b01;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = SKIP;
        end
      end
      SKIP: if (take && is_delim) state_d = IDLE;
      default: if (bus.word_ready) begin
        word_valid_d = 1'b0;
        acc_d        = '0;
        cnt_d        = '0;
        state_d      = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      word_data_q  <= '0;
      word_ndig_q  <= '0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      word_data_q  <= word_data_d;
      word_ndig_q  <= word_ndig_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end
  assign bus.word_valid = word_valid_q;
  assign bus.word_data  = word_data_q;
  assign bus.word_ndig  = word_ndig_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
endmodule

// File: tb/tb_asc_hex_parser.sv
// tb_asc_hex_parser: token-level reference model, per-cycle compare, directed and random stimulus
module tb_asc_hex_parser;
  localparam int D = 8;
  localparam int W = 4 * D;
`ifdef ASC_HEX_UPPER_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  asc_hex_parser_if #(.DIGITS(D)) bus();
  asc_hex_parser #(.DIGITS(D)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [63:0] tok_val;
  int tok_len;
  bit tok_bad;
  bit m_valid, m_err;
  logic [W-1:0] m_data;
  int m_ndig;
  logic [1:0] m_code;
  bit accepted;
  int words = 0;
  int errs = 0;
  logic [W-1:0] last_word;
  int last_ndig;
  function automatic int hexval(logic [7:0] ch);
    if (ch >= "0" && ch <= "9") return int'(ch) - 48;
    if (ch >= "a" && ch <= "f") return int'(ch) - 87;
    if (UP && ch >= "A" && ch <= "F") return int'(ch) - 55;
    return -1;
  endfunction
  function automatic bit delim(logic [7:0] ch);
    return ch == 8'h0D || ch == 8'h0A || ch == 8'h20 || ch == 8'h2C;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_edge();
    int v;
    accepted = 1'b0;
    if (!rst_n) begin
      tok_val = 0; tok_len = 0; tok_bad = 0;
      m_valid = 0; m_err = 0; m_data = '0; m_ndig = 0; m_code = 0;
    end else begin
      m_err = 0;
      if (m_valid) begin
        if (bus.word_ready) m_valid = 0;
      end else if (bus.char_valid) begin
        accepted = 1'b1;
        v = hexval(bus.char_data);
        if (delim(bus.char_data)) begin
          if (tok_len > 0 && !tok_bad) begin
            m_valid = 1; m_data = W'(tok_val); m_ndig = tok_len;
          end
          tok_val = 0; tok_len = 0; tok_bad = 0;
        end else if (tok_bad) begin
        end else if (v < 0) begin
          m_err = 1; m_code = 2'd1; tok_bad = 1;
        end else if (tok_len == D) begin
          m_err = 1; m_code = 2'd2; tok_bad = 1;
        end else begin
          tok_val = tok_val * 16 + 64'(v);
          tok_len++;
        end
      end
    end
  endtask
  task automatic cycle();
    model_edge();
    if (rst_n && bus.word_valid && bus.word_ready) begin
      words++;
      last_word = bus.word_data;
      last_ndig = int'(bus.word_ndig);
    end
    @(posedge clk);
    @(negedge clk);
    chk("char_ready", bus.char_ready, rst_n && !m_valid);
    chk("word_valid", bus.word_valid, m_valid);
    chk("err", bus.err, m_err);
    chk("err_code", bus.err_code, m_code);
    chk("word_data", bus.word_data, m_data);
    chk("word_ndig", bus.word_ndig, m_ndig);
    if (bus.err) errs++;
  endtask
  task automatic send(logic [7:0] ch);
    bus.char_valid = 1'b1;
    bus.char_data = ch;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (accepted) break;
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL send_timeout: char %0h never accepted", ch);
    end
    bus.char_valid = 1'b0;
  endtask
  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  initial begin
    int w0, e0, r;
    string hx;
    string uc;
    logic [7:0] dl [4];
    hx = "0123456789abcdef";
    uc = "ABCDEF";
    dl = '{8'h0D, 8'h0A, 8'h20, 8'h2C};
    bus.char_valid = 1'b0;
    bus.char_data = 8'h00;
    bus.word_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    chk("reset_char_ready", bus.char_ready, 0);
    chk("reset_code", bus.err_code, 0);
    rst_n = 1'b1;
    cycle();
    w0 = words; e0 = errs;
    send_str("1a3");
    send(8'h0D);
    cycle();
    chk("t1_words", words, w0 + 1);
    chk("t1_data", last_word, 'h1A3);
    chk("t1_ndig", last_ndig, 3);
    chk("t1_errs", errs, e0);
    w0 = words; e0 = errs;
    send_str("FF");
    send(8'h0A);
    cycle();
    if (UP) begin
      chk("t2_words", words, w0 + 1);
      chk("t2_data", last_word, 'hFF);
      chk("t2_ndig", last_ndig, 2);
    end else begin
      chk("t2_words", words, w0);
      chk("t2_errs", errs, e0 + 1);
      chk("t2_code", bus.err_code, 1);
    end
    w0 = words; e0 = errs;
    send_str("123456789 ");
    chk("t3_errs", errs, e0 + 1);
    chk("t3_code", bus.err_code, 2);
    chk("t3_words", words, w0);
    send_str("7 ");
    cycle();
    chk("t3_words2", words, w0 + 1);
    chk("t3_data", last_word, 'h7);
    chk("t3_ndig", last_ndig, 1);
    w0 = words;
    bus.word_ready = 1'b0;
    send_str("ab ");
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t4_ready_low", bus.char_ready, 0);
      chk("t4_hold", bus.word_data, 'hAB);
    end
    chk("t4_no_word", words, w0);
    bus.word_ready = 1'b1;
    cycle();
    cycle();
    chk("t4_words", words, w0 + 1);
    chk("t4_data", last_word, 'hAB);
    chk("t4_released", bus.word_valid, 0);
    w0 = words;
    send_str("12");
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    send_str("3 ");
    cycle();
    chk("t5_words", words, w0 + 1);
    chk("t5_data", last_word, 'h3);
    chk("t5_ndig", last_ndig, 1);
    w0 = words; e0 = errs;
    bus.char_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.char_data = (i == 0) ? 8'h20 : (i == 1) ? 8'h2C : 8'h0D;
      cycle();
      chk("t6_ready", bus.char_ready, 1);
    end
    bus.char_valid = 1'b0;
    cycle();
    chk("t6_words", words, w0);
    chk("t6_errs", errs, e0);
    for (int i = 0; i < 4000; i++) begin
      rst_n = $urandom_range(0, 199) != 0;
      bus.word_ready = $urandom_range(0, 9) < 7;
      bus.char_valid = $urandom_range(0, 9) < 8;
      r = $urandom_range(0, 99);
      if (r < 45) bus.char_data = hx[$urandom_range(0, 15)];
      else if (r < 55) bus.char_data = uc[$urandom_range(0, 5)];
      else if (r < 80) bus.char_data = dl[$urandom_range(0, 3)];
      else bus.char_data = 8'($urandom_range(0, 255));
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
